// File: rtl/data_mem_mmio.sv
// Data-side memory stage: word RAM plus an MMIO block (LEDs, TX byte FIFO,
// status, cycle counter). Loads are combinational so the single-cycle core never stalls.
module data_mem_mmio #(
   parameter int RAM_WORDS  = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic [7:0]  leds,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [29:0]   LED_WA    = 30'h2000_0000;
   localparam logic [29:0]   TXDATA_WA = 30'h2000_0001;
   localparam logic [29:0]   STATUS_WA = 30'h2000_0002;
   localparam logic [29:0]   CYCLES_WA = 30'h2000_0003;
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_LED,
      SEL_TX,
      SEL_STATUS,
      SEL_CYCLES
   } sel_e;

   sel_e          sel;
   logic [29:0]   word_addr;
   logic [31:0]   mem [RAM_WORDS];
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [3:0]    count4;
   logic          overflow;
   logic          full;
   logic          empty;
   logic          push_req;
   logic          push;
   logic          pop;
   logic          ovf_set;
   logic          ovf_clr;
   logic [31:0]   cycles;
   logic          unused_byte_offset;

   // Word access only: the byte offset takes no part in decode.
   assign word_addr          = ALUResult[31:2];
   assign unused_byte_offset = ^ALUResult[1:0];

   // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      sel = SEL_NONE;
      if (word_addr[29:AW] == '0) begin
         sel = SEL_RAM;
      end else begin
         case (word_addr)
            LED_WA:    sel = SEL_LED;
            TXDATA_WA: sel = SEL_TX;
            STATUS_WA: sel = SEL_STATUS;
            CYCLES_WA: sel = SEL_CYCLES;
            default:   sel = SEL_NONE;
         endcase
      end
   end

   assign empty    = (count == '0);
   assign full     = (count == CNT_FULL);
   assign tx_valid = !empty;
   assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
   assign pop      = tx_valid && tx_ready;
   assign push_req = MemWrite && (sel == SEL_TX);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push     = push_req && (!full || pop);
   assign ovf_set  = push_req && full && !pop;
   assign ovf_clr  = MemWrite && (sel == SEL_STATUS) && WriteData[2];
   assign count4   = 4'(count);

   // NOTE: RAM and FIFO storage carry no reset; only the control state is cleared, so these map onto plain memory.
   always_ff @(posedge clk) begin
      if (MemWrite && (sel == SEL_RAM)) mem[word_addr[AW-1:0]] <= WriteData;
      if (push) fifo_mem[wr_ptr] <= WriteData[7:0];
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         leds     <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         cycles   <= '0;
      end else begin
         cycles <= cycles + 32'd1;
         if (MemWrite && (sel == SEL_LED)) leds <= WriteData[7:0];
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (ovf_set)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   always_comb begin
      ReadData = '0;
      case (sel)
         SEL_RAM:    ReadData = mem[word_addr[AW-1:0]];
         SEL_LED:    ReadData = {24'b0, leds};
         SEL_STATUS: ReadData = {25'b0, count4, overflow, full, empty};
         SEL_CYCLES: ReadData = cycles;
         default:    ReadData = '0;
      endcase
   end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboard bench for data_mem_mmio: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_data_mem_mmio;

   localparam logic [31:0] A_LED    = 32'h8000_0000;
   localparam logic [31:0] A_TX     = 32'h8000_0004;
   localparam logic [31:0] A_STATUS = 32'h8000_0008;
   localparam logic [31:0] A_CYCLES = 32'h8000_000C;

   typedef enum logic [1:0] {K_RD, K_LEDS, K_TXV} kind_e;
   typedef struct {
      kind_e       kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        MemWrite;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic [7:0]  leds;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   logic        probe;
   exp_t        exp_q[$];
   logic [7:0]  tx_q[$];
   exp_t        cur;
   logic [7:0]  tx_exp;
   int          n_vec;
   int          n_bad;

   data_mem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .ALUResult (ALUResult),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .leds      (leds),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
      end
   endtask

   // Monitor: compares whenever a probe is presented or the FIFO hands off a byte.
   always @(negedge clk) begin
      if (probe) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_underflow: probe with no expected value queued");
         end else begin
            cur = exp_q.pop_front();
            case (cur.kind)
               K_RD:    check(cur.name, ReadData, cur.val);
               K_LEDS:  check(cur.name, {24'b0, leds}, cur.val);
               default: check(cur.name, {31'b0, tx_valid}, cur.val);
            endcase
         end
      end
      if (reset && tx_valid && tx_ready) begin
         if (tx_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL tx_unexpected: got byte %02h, expected no transfer", tx_data);
         end else begin
            tx_exp = tx_q.pop_front();
            check("tx_byte", {24'b0, tx_data}, {24'b0, tx_exp});
         end
      end
   end

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      ALUResult = a;
      WriteData = d;
      MemWrite  = 1'b1;
      @(posedge clk);
      #1;
      MemWrite  = 1'b0;
   endtask

   task automatic expect_k(input kind_e k, input logic [31:0] a, input logic [31:0] v, input string nm);
      exp_t e;
      e.kind = k;
      e.val  = v;
      e.name = nm;
      ALUResult = a;
      MemWrite  = 1'b0;
      exp_q.push_back(e);
      probe = 1'b1;
      @(posedge clk);
      #1;
      probe = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] v, input string nm);
      expect_k(K_RD, a, v, nm);
   endtask

   initial begin
      n_vec     = 0;
      n_bad     = 0;
      probe     = 1'b0;
      reset     = 1'b0;
      MemWrite  = 1'b0;
      ALUResult = '0;
      WriteData = '0;
      tx_ready  = 1'b0;

      // Reset for 3 cycles; counter holds 0 until the first edge after release.
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      expect_k(K_LEDS, 32'h0, 32'h0, "reset_leds");
      expect_k(K_TXV, 32'h0, 32'h0, "reset_tx_valid");
      rd(A_STATUS, 32'h0000_0001, "reset_status");
      rd(A_CYCLES, 32'd3, "cycles_first");
      @(posedge clk);
      #1;
      rd(A_CYCLES, 32'd5, "cycles_plus2");

      // RAM store/load, byte offset ignored, unwritten neighbour leaves 0x10 intact.
      wr(32'h0000_0010, 32'hDEAD_BEEF);
      rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_load_10");
      rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_load_13");
      ALUResult = 32'h0000_0014;
      @(posedge clk);
      #1;
      rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_no_corrupt");

      // LED register and unmapped writes.
      wr(A_LED, 32'h1234_56A5);
      expect_k(K_LEDS, 32'h0, 32'h0000_00A5, "leds_set");
      rd(A_LED, 32'h0000_00A5, "led_readback");
      wr(32'h8000_0100, 32'h0000_00FF);
      expect_k(K_LEDS, 32'h0, 32'h0000_00A5, "leds_unmapped_wr");
      rd(32'h8000_0100, 32'h0, "unmapped_read");
      wr(A_CYCLES, 32'h0);
      rd(32'hFFFF_FFF0, 32'h0, "unmapped_high_read");

      // FIFO fill, overflow, overflow clear.
      foreach (tx_q[i]) tx_q.delete();
      wr(A_TX, 32'h11);
      wr(A_TX, 32'h22);
      wr(A_TX, 32'h33);
      wr(A_TX, 32'h44);
      rd(A_STATUS, 32'h0000_0022, "status_full");
      wr(A_TX, 32'h55);
      rd(A_STATUS, 32'h0000_0026, "status_overflow");
      rd(A_TX, 32'h0, "txdata_read_zero");
      wr(A_STATUS, 32'h0000_0004);
      rd(A_STATUS, 32'h0000_0022, "status_ovf_cleared");

      // Drain: one byte per cycle, 0x55 was dropped.
      tx_q.push_back(8'h11);
      tx_q.push_back(8'h22);
      tx_q.push_back(8'h33);
      tx_q.push_back(8'h44);
      tx_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      expect_k(K_TXV, 32'h0, 32'h0, "drained_tx_valid");
      rd(A_STATUS, 32'h0000_0001, "drained_status");
      check("drain_complete", 32'(tx_q.size()), 32'd0);

      // Full with simultaneous push and pop, then reset mid-drain.
      tx_ready = 1'b0;
      wr(A_TX, 32'h31);
      wr(A_TX, 32'h32);
      wr(A_TX, 32'h33);
      wr(A_TX, 32'h34);
      tx_q.push_back(8'h31);
      tx_q.push_back(8'h32);
      tx_q.push_back(8'h33);
      tx_q.push_back(8'h34);
      tx_q.push_back(8'h66);
      tx_ready = 1'b1;
      wr(A_TX, 32'h66);
      tx_ready = 1'b0;
      rd(A_STATUS, 32'h0000_0022, "status_push_pop_full");
      tx_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      tx_q.delete();
      expect_k(K_TXV, 32'h0, 32'h0, "mid_reset_tx_valid");
      expect_k(K_LEDS, 32'h0, 32'h0, "mid_reset_leds");
      reset    = 1'b1;
      tx_ready = 1'b0;
      rd(A_STATUS, 32'h0000_0001, "post_reset_status");

      check("tx_queue_empty", 32'(tx_q.size()), 32'd0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/data_mem_mmio.md
Name: data_mem_mmio

Overview:
Data-side memory stage that consumes the CPU core's MemWrite/ALUResult/WriteData and returns ReadData in the same cycle, so the single-cycle core needs no stall.
- Decodes the address into a word RAM and a small MMIO space: LED register, byte-wide TX FIFO with a valid/ready drain port, status register, and free-running cycle counter.
- Sits between the CPU top and board-level peripherals.

Parameters:
RAM_WORDS, 64, depth of data RAM in 32-bit words (power of 2, ≤ 1024)
FIFO_DEPTH, 4, TX FIFO entries (power of 2, 2..8)

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately
MemWrite  input  1  store strobe from core, valid this cycle
ALUResult  input  32  byte address; bits[1:0] ignored (word access only)
WriteData  input  32  store data
ReadData  output  32  load data, combinational from ALUResult/state
leds  output  8  LED register contents
tx_data  output  8  FIFO head byte
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  consumer accepts head when tx_valid&tx_ready at clock edge

Behaviour:
- Reset (reset=0, asynchronous): leds=0, FIFO empty (count=0, pointers 0, tx_valid=0, tx_data=0), overflow=0, cycle counter=0. RAM contents not reset (X until written).
- Address map (A=ALUResult):
  - RAM: A < RAM_WORDS*4. Read: ReadData=mem[A[log2(RAM_WORDS)+1:2]] combinational. Write: on clk edge when MemWrite.
  - 0x8000_0000 LED: read {24'b0,leds}; write sets leds=WriteData[7:0] next edge.
  - 0x8000_0004 TXDATA: read 0. Write pushes WriteData[7:0].
  - 0x8000_0008 STATUS: read {25'b0, count[3:0] at bits[6:3], overflow bit2, full bit1, empty bit0}. Write with WriteData[2]=1 clears overflow; other bits ignored.
  - 0x8000_000C CYCLES: read current counter value (pre-increment). Writes ignored.
  - Any other address: read 0, write ignored, no side effect.
- Cycle counter: +1 every clk edge out of reset, 32-bit, wraps 0xFFFF_FFFF→0.
- FIFO:
  - pop = tx_valid & tx_ready.
  - push_req = MemWrite & A==TXDATA.
  - Push accepted when count<FIFO_DEPTH or pop in the same cycle. Full & push & pop: both occur, count unchanged.
  - push_req while full without pop: byte dropped, overflow←1 (sticky).
  - Empty & push: tx_valid rises on the next edge (no same-cycle fall-through). tx_data=head entry, registered/stable while tx_valid & !tx_ready.
  - Pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
  - empty = (count==0); full = (count==FIFO_DEPTH).
- Overflow set and clear in the same cycle cannot occur: different addresses, one access per cycle.
- Reset mid-operation: FIFO contents discarded, tx_valid drops asynchronously; leds and counter zero immediately.
- ReadData depends only on ALUResult and current registered state, never on this cycle's write data.

Test Plan:
1. Reset with reset=0 for 3 cycles, release → leds=0, tx_valid=0; read 0x8000_0008 = 0x0000_0001; read 0x8000_000C two cycles apart differs by 2.
2. RAM: store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 and 0x0000_0013 → both 0xDEADBEEF. Load 0x0000_0014 without a prior write → X (unwritten), no corruption of 0x10.
3. LED: store 0x1234_56A5 to 0x8000_0000 → leds=0xA5 next cycle, readback 0x0000_00A5. Store to 0x8000_0100 → leds unchanged, read 0.
4. FIFO fill/overflow with tx_ready=0: push 0x11,0x22,0x33,0x44 → STATUS=0x22 (count 4, full). Push 0x55 → STATUS=0x26 (overflow set). Write 0x4 to STATUS → 0x22.
5. Drain, tx_ready=1 → tx_data 0x11,0x22,0x33,0x44 on consecutive cycles, then tx_valid=0, STATUS=0x01; 0x55 never appears.
6. Full with simultaneous push 0x66 and pop → count stays 4, no overflow; 0x66 emerges after 0x44. Assert reset mid-drain → tx_valid=0 immediately, STATUS=0x01 after release.
